drop_sequencer: RTL and testbench
=================================

DROP_SEQUENCER -- requirements
Module: drop_sequencer

Interface
REQ-001 Parameter NUM_COLS, 7, number of board columns.
REQ-002 Parameter NUM_ROWS, 6, number of board rows.
REQ-003 Parameter PIXELS, 16, pixels per token; the token is 4x4 and indexed by pixel_count.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 col_sel  input  3  player's selected column, 0-6; values 7 are invalid.
REQ-007 move_req  input  1  one-cycle pulse: draw hover preview at col_sel.
REQ-008 drop_req  input  1  one-cycle pulse: drop current player's token into col_sel.
REQ-009 pixel_count  output  4  pixel index to datapath, 0-15.
REQ-010 location  output  3  column to datapath, latched at request acceptance.
REQ-011 decoded_height  output  3  landing row to datapath, 0 = top row.
REQ-012 go  output  1  1 = drop draw (board row), 0 = preview draw (hover row).
REQ-013 player  output  1  current player, 0 or 1.
REQ-014 plot  output  1  VGA write enable, aligned with datapath registered x/y.
REQ-015 busy  output  1  high while not in IDLE or FULL.
REQ-016 done  output  1  one-cycle pulse when a drop is committed.
REQ-017 reject  output  1  one-cycle pulse when a request is refused.
REQ-018 board_full  output  1  high once all 42 cells are filled.

Function
REQ-019 States: IDLE, PREVIEW, DROP, COMMIT, FULL.
REQ-020 Requests are sampled only in IDLE; any request arriving in other states is ignored and is not queued.
REQ-021 IDLE with drop_req, valid col_sel and fill[col_sel] < NUM_ROWS goes to DROP.
- Latches location=col_sel, decoded_height=NUM_ROWS-1-fill[col_sel], go=1.
REQ-022 IDLE with drop_req and (col_sel invalid or column full): reject=1 next cycle, state stays IDLE.
REQ-023 IDLE with move_req, valid col_sel and no drop_req goes to PREVIEW.
- Latches location, go=0.
- Invalid col_sel gives reject.
REQ-024 If drop_req and move_req are both high in the same cycle, drop_req wins and move_req is discarded.
REQ-025 PREVIEW and DROP drive pixel_count 0,1,...,15 on consecutive cycles, starting at 0 in the first state cycle.
REQ-026 PREVIEW exits to IDLE after count 15.
REQ-027 DROP exits to COMMIT after count 15.
REQ-028 plot is a one-cycle-delayed registered copy of (state==PREVIEW or DROP).
- This gives exactly 16 plot cycles, the last one in the exit cycle.
REQ-029 location, decoded_height and go are held stable from acceptance through the cycle after the last count.
REQ-030 COMMIT lasts one cycle and performs all of the following:
- increments fill[location];
- increments total count (6 bits);
- pulses done;
- toggles player on exit.
REQ-031 COMMIT goes to FULL if the total reaches NUM_COLS*NUM_ROWS (42); otherwise it goes to IDLE.
REQ-032 FULL asserts board_full and rejects every drop_req and move_req with a reject pulse.
- FULL is left only by reset.
REQ-033 player changes only on COMMIT exit; it never changes during PREVIEW.
REQ-034 Column fill counters saturate at NUM_ROWS.
- An accepted drop never targets a full column.
REQ-035 pixel_count wraps 15 to 0 only on state entry and never increments outside PREVIEW/DROP.

Reset
REQ-036 resetn low forces the following immediately, independent of clk:
- state IDLE;
- all fill counters 0 and total 0;
- player 0;
- pixel_count 0, location 0, decoded_height 0, go 0;
- plot, busy, done, reject and board_full all 0.
REQ-037 Reset mid-draw aborts the draw with no commit.
- plot is low in the first cycle after resetn is released.

Structure
REQ-038 The shared package holds:
- NUM_COLS, NUM_ROWS, PIXELS;
- the total-cell constant (42);
- the state enumeration.
REQ-039 The sub-module column_height_table holds the 7 x 3-bit fill counters.
- It provides a combinational read port, an increment port and a full flag per column.

Verification
REQ-040 Drop: reset, player 0, drop_req with col_sel=3 -> next 16 cycles pixel_count 0..15 with location=3, decoded_height=5, go=1.
- plot high for 16 cycles, offset by 1.
- done pulses, then player=1.
REQ-041 Column fill: 6 drops into column 0 -> decoded_height goes 5,4,3,2,1,0.
- The 7th drop gives reject with no draw, and player is unchanged.
REQ-042 Preview: move_req with col_sel=6 -> 16 plot cycles with go=0, location=6.
- No done pulse, player unchanged, fill unchanged.
REQ-043 Busy and collision: drop_req during DROP is ignored.
- Simultaneous move_req+drop_req in IDLE gives a drop draw only.
- col_sel=7 gives reject.
REQ-044 Board full: 42 valid drops -> board_full=1 after the 42nd done.
- A later drop_req gives reject.
REQ-045 Reset mid-draw: resetn low at pixel_count=8 -> plot and pixel_count are 0 immediately.
- After release, fill is 0 and player is 0.

Source files
------------

// File: rtl/drop_sequencer_pkg.sv
// Shared constants and state encoding for the token drop sequencer.
package drop_sequencer_pkg;

  localparam int unsigned NUM_COLS    = 7;
  localparam int unsigned NUM_ROWS    = 6;
  localparam int unsigned PIXELS      = 16;
  localparam int unsigned TOTAL_CELLS = NUM_COLS * NUM_ROWS;

  localparam int unsigned COL_W   = 3;
  localparam int unsigned FILL_W  = 3;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned TOTAL_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    PREVIEW,
    DROP,
    COMMIT,
    FULL
  } state_t;

endpackage

// File: rtl/column_height_table.sv
// Per-column fill counters with a combinational read port and saturating increment.
module column_height_table
  import drop_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic [COL_W-1:0]    rd_col,
  output logic [FILL_W-1:0]   rd_fill_c,
  input  logic                inc_en,
  input  logic [COL_W-1:0]    inc_col,
  output logic [NUM_COLS-1:0] col_full_c
);

  logic [FILL_W-1:0] fill [NUM_COLS];

  // Saturating increment; out-of-range columns are ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_COLS; i++) fill[i] <= '0;
    end else if (inc_en && (inc_col < COL_W'(NUM_COLS)) &&
                 (fill[inc_col] < FILL_W'(NUM_ROWS))) begin
      fill[inc_col] <= fill[inc_col] + FILL_W'(1);
    end
  end

  assign rd_fill_c = (rd_col < COL_W'(NUM_COLS)) ? fill[rd_col] : '0;

  always_comb begin
    col_full_c = '0;
    for (int i = 0; i < NUM_COLS; i++) col_full_c[i] = (fill[i] == FILL_W'(NUM_ROWS));
  end

endmodule

// File: rtl/drop_sequencer.sv
// Sequences hover-preview and drop draws of a 4x4 token, tracks column fill and turn order.
module drop_sequencer
  import drop_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [COL_W-1:0]   col_sel,
  input  logic               move_req,
  input  logic               drop_req,
  output logic [PIX_W-1:0]   pixel_count,
  output logic [COL_W-1:0]   location,
  output logic [FILL_W-1:0]  decoded_height,
  output logic               go,
  output logic               player,
  output logic               plot,
  output logic               busy,
  output logic               done,
  output logic               reject,
  output logic               board_full
);

  state_t               state;
  logic [TOTAL_W-1:0]   total;
  logic [FILL_W-1:0]    rd_fill_c;
  logic [NUM_COLS-1:0]  col_full_c;
  logic                 col_ok_c;
  logic                 inc_en_c;

  assign col_ok_c = (col_sel < COL_W'(NUM_COLS));
  assign inc_en_c = (state == COMMIT);

  column_height_table u_heights (
    .clk        (clk),
    .resetn     (resetn),
    .rd_col     (col_sel),
    .rd_fill_c  (rd_fill_c),
    .inc_en     (inc_en_c),
    .inc_col    (location),
    .col_full_c (col_full_c)
  );

  // Sequencer: requests are only looked at in IDLE (and refused in FULL).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      total          <= '0;
      player         <= 1'b0;
      pixel_count    <= '0;
      location       <= '0;
      decoded_height <= '0;
      go             <= 1'b0;
      plot           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      reject         <= 1'b0;
      board_full     <= 1'b0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      plot   <= (state == PREVIEW) || (state == DROP);
      unique case (state)
        IDLE: begin
          if (drop_req) begin
            if (col_ok_c && !col_full_c[col_sel]) begin
              state          <= DROP;
              location       <= col_sel;
              decoded_height <= FILL_W'(NUM_ROWS - 1) - rd_fill_c;
              go             <= 1'b1;
              pixel_count    <= '0;
              busy           <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end else if (move_req) begin
            if (col_ok_c) begin
              state       <= PREVIEW;
              location    <= col_sel;
              go          <= 1'b0;
              pixel_count <= '0;
              busy        <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        PREVIEW, DROP: begin
          if (pixel_count == PIX_W'(PIXELS - 1)) begin
            if (state == DROP) begin
              state <= COMMIT;
              done  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pixel_count <= pixel_count + PIX_W'(1);
          end
        end
        COMMIT: begin
          total  <= total + TOTAL_W'(1);
          player <= ~player;
          busy   <= 1'b0;
          if (total == TOTAL_W'(TOTAL_CELLS - 1)) begin
            state      <= FULL;
            board_full <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        FULL: begin
          if (drop_req || move_req) reject <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer: a reference model queues the expected outcome of each request.
module tb_drop_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] col_sel;
  logic       move_req;
  logic       drop_req;
  logic [3:0] pixel_count;
  logic [2:0] location;
  logic [2:0] decoded_height;
  logic       go;
  logic       player;
  logic       plot;
  logic       busy;
  logic       done;
  logic       reject;
  logic       board_full;

  drop_sequencer dut (
    .clk            (clk),
    .resetn         (resetn),
    .col_sel        (col_sel),
    .move_req       (move_req),
    .drop_req       (drop_req),
    .pixel_count    (pixel_count),
    .location       (location),
    .decoded_height (decoded_height),
    .go             (go),
    .player         (player),
    .plot           (plot),
    .busy           (busy),
    .done           (done),
    .reject         (reject),
    .board_full     (board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_rej;
    bit go;
    int loc;
    int hgt;
    bit ply;
    bit full;
  } exp_t;

  exp_t sbq[$];
  int   fill_m [7];
  int   total_m;
  bit   player_m;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) fill_m[i] = 0;
    total_m  = 0;
    player_m = 1'b0;
  endtask

  // Model the request, queue the expectation, then pulse it for one cycle.
  task automatic request(input bit d, input bit m, input int col);
    exp_t e;
    e = '{is_rej: 1'b1, go: 1'b0, loc: col, hgt: 0, ply: player_m, full: 1'b0};
    if (total_m == 42) begin
      e.is_rej = 1'b1;
    end else if (d) begin
      if (col < 7 && fill_m[col] < 6) begin
        e.is_rej = 1'b0;
        e.go     = 1'b1;
        e.hgt    = 5 - fill_m[col];
        fill_m[col]++;
        total_m++;
        player_m = ~player_m;
      end
    end else if (m && col < 7) begin
      e.is_rej = 1'b0;
      e.go     = 1'b0;
    end
    e.ply  = player_m;
    e.full = (total_m == 42);
    sbq.push_back(e);
    @(negedge clk);
    col_sel  = 3'(col);
    drop_req = d;
    move_req = m;
    @(negedge clk);
    drop_req = 1'b0;
    move_req = 1'b0;
  endtask

  // Pop the expectation and compare the DUT response; inj >= 0 pulses a stray drop mid-draw.
  task automatic observe(input int inj);
    exp_t e;
    int   plots;
    e = sbq.pop_front();
    if (e.is_rej) begin
      chk("reject_pulse", reject, 1);
      chk("reject_no_plot", plot, 0);
      chk("reject_not_busy", busy, 0);
      @(negedge clk);
      chk("reject_clear", reject, 0);
      chk("reject_player", player, e.ply);
      chk("reject_full", board_full, e.full);
    end else begin
      plots = 0;
      for (int k = 0; k < 16; k++) begin
        chk("pixel_count", pixel_count, k);
        if (k == 0) begin
          chk("location", location, e.loc);
          chk("go", go, e.go);
          chk("busy", busy, 1);
          if (e.go) chk("height", decoded_height, e.hgt);
        end
        if (plot) plots++;
        if (k == inj) begin
          col_sel  = 3'd2;
          drop_req = 1'b1;
        end else begin
          drop_req = 1'b0;
        end
        @(negedge clk);
      end
      drop_req = 1'b0;
      if (plot) plots++;
      chk("done_in_exit", done, e.go);
      chk("location_held", location, e.loc);
      if (e.go) chk("height_held", decoded_height, e.hgt);
      @(negedge clk);
      if (plot) plots++;
      chk("plot_cycles", plots, 16);
      chk("done_clear", done, 0);
      chk("busy_after", busy, 0);
      chk("player_after", player, e.ply);
      chk("full_after", board_full, e.full);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    col_sel  = '0;
    move_req = 1'b0;
    drop_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pixel", pixel_count, 0);
    chk("rst_location", location, 0);
    chk("rst_height", decoded_height, 0);
    chk("rst_flags", {go, player, plot, busy, done, reject, board_full}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single drop into column 3.
    request(1, 0, 3); observe(-1);

    // Fill column 0, then overflow it.
    for (int i = 0; i < 7; i++) begin
      request(1, 0, 0); observe(-1);
    end

    // Preview leaves fill and turn alone; a drop into 6 still lands on row 5.
    request(0, 1, 6); observe(-1);
    request(1, 0, 6); observe(-1);

    // Stray drop during a draw is ignored; column 2 still empty afterwards.
    request(1, 0, 5); observe(5);
    request(1, 0, 2); observe(-1);

    // Collision resolves to drop; invalid column refused for both kinds.
    request(1, 1, 4); observe(-1);
    request(0, 1, 7); observe(-1);
    request(1, 0, 7); observe(-1);

    // Reset in the middle of a drop draw.
    @(negedge clk);
    col_sel  = 3'd1;
    drop_req = 1'b1;
    @(negedge clk);
    drop_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_pixel", pixel_count, 8);
    resetn = 1'b0;
    #1;
    chk("midrst_plot", plot, 0);
    chk("midrst_pixel", pixel_count, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post_rst_plot", plot, 0);
    chk("post_rst_player", player, 0);
    request(1, 0, 1); observe(-1);

    // Fill the whole board: 41 more drops after the one above.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        if (!(r == 0 && c == 1)) begin
          request(1, 0, (c + r) % 7); observe(-1);
        end
      end
    end
    chk("board_full", board_full, 1);
    request(1, 0, 3); observe(-1);
    request(0, 1, 2); observe(-1);
    chk("queue_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
